// File: rtl/spi_reg_sequencer.sv
// SPI word-level command sequencer: header decode, burst register write/read with auto-increment.
// Optional status word at the all-ones address is enabled by defining SPI_SEQ_STATUS_EN.
module spi_reg_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              SSEL_ACTIVE,
    input  logic              WORD_VALID,
    input  logic [15:0]       WORD_IN,
    output logic              TX_LOAD,
    output logic [15:0]       TX_WORD,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [15:0]       REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [15:0]       REG_RDATA,
    input  logic              REG_RVALID,
    output logic              BUSY,
    output logic              ERR
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR, WR, RD_WAIT, RD_HOLD, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n, addr_inc, hdr_addr, reg_addr_n;
    logic [7:0]        count, count_n;
    logic [TW-1:0]     timer, timer_n;
    logic [15:0]       tx_word_n, wdata_n;
    logic              tx_load_n, we_n, re_n, err_n;
    logic              stat_pend, stat_pend_n;
    logic              hdr_stat, inc_stat, cur_stat;

    assign hdr_addr = WORD_IN[8 +: ADDR_W];
    assign addr_inc = addr + ADDR_W'(1);
    assign BUSY     = (state != IDLE);

`ifdef SPI_SEQ_STATUS_EN
    assign hdr_stat = (hdr_addr == '1);
    assign inc_stat = (addr_inc == '1);
    assign cur_stat = (addr == '1);
`else
    assign hdr_stat = 1'b0;
    assign inc_stat = 1'b0;
    assign cur_stat = 1'b0;
`endif

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            timer     <= '0;
            stat_pend <= 1'b0;
            TX_LOAD   <= 1'b0;
            TX_WORD   <= '0;
            REG_ADDR  <= '0;
            REG_WDATA <= '0;
            REG_WE    <= 1'b0;
            REG_RE    <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            count     <= count_n;
            timer     <= timer_n;
            stat_pend <= stat_pend_n;
            TX_LOAD   <= tx_load_n;
            TX_WORD   <= tx_word_n;
            REG_ADDR  <= reg_addr_n;
            REG_WDATA <= wdata_n;
            REG_WE    <= we_n;
            REG_RE    <= re_n;
            ERR       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        count_n     = count;
        timer_n     = timer;
        stat_pend_n = 1'b0;
        reg_addr_n  = REG_ADDR;
        wdata_n     = REG_WDATA;
        tx_word_n   = TX_WORD;
        tx_load_n   = 1'b0;
        we_n        = 1'b0;
        re_n        = 1'b0;
        err_n       = ERR;
        // Slave-select drop overrides everything, including a word arriving in the same cycle.
        if (!SSEL_ACTIVE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = HDR;
                HDR: if (WORD_VALID) begin
                    addr_n  = hdr_addr;
                    count_n = WORD_IN[7:0];
                    err_n   = 1'b0;
                    if (WORD_IN[7:0] == 8'd0) begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end else if (WORD_IN[15]) begin
                        state_n = WR;
                    end else begin
                        reg_addr_n  = hdr_addr;
                        timer_n     = '0;
                        stat_pend_n = hdr_stat;
                        re_n        = !hdr_stat;
                        state_n     = RD_WAIT;
                    end
                end
                WR: if (WORD_VALID) begin
                    if (cur_stat) begin
                        err_n = 1'b0;
                    end else begin
                        we_n       = 1'b1;
                        wdata_n    = WORD_IN;
                        reg_addr_n = addr;
                    end
                    addr_n  = addr_inc;
                    count_n = count - 8'd1;
                    if (count == 8'd1) state_n = DRAIN;
                end
                RD_WAIT: begin
                    if (WORD_VALID) begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end else if (stat_pend) begin
                        tx_word_n = {ERR, BUSY, 6'b0, count};
                        tx_load_n = 1'b1;
                        state_n   = RD_HOLD;
                    end else if (REG_RVALID) begin
                        tx_word_n = REG_RDATA;
                        tx_load_n = 1'b1;
                        state_n   = RD_HOLD;
                    end else if (timer == TW'(RD_TIMEOUT - 1)) begin
                        err_n     = 1'b1;
                        tx_word_n = 16'hDEAD;
                        tx_load_n = 1'b1;
                        state_n   = DRAIN;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                RD_HOLD: if (WORD_VALID) begin
                    count_n = count - 8'd1;
                    if (count == 8'd1) begin
                        state_n = DRAIN;
                    end else begin
                        addr_n      = addr_inc;
                        reg_addr_n  = addr_inc;
                        timer_n     = '0;
                        stat_pend_n = inc_stat;
                        re_n        = !inc_stat;
                        state_n     = RD_WAIT;
                    end
                end
                DRAIN: state_n = DRAIN;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer with write/reply scoreboards and a delayed-reply bus model.
module tb_spi_reg_sequencer;
    localparam int ADDR_W     = 7;
    localparam int RD_TIMEOUT = 64;

    logic              SYS_CLK = 1'b0;
    logic              RST = 1'b1;
    logic              SSEL_ACTIVE = 1'b0;
    logic              WORD_VALID = 1'b0;
    logic [15:0]       WORD_IN = '0;
    logic              TX_LOAD;
    logic [15:0]       TX_WORD;
    logic [ADDR_W-1:0] REG_ADDR;
    logic [15:0]       REG_WDATA;
    logic              REG_WE;
    logic              REG_RE;
    logic [15:0]       REG_RDATA = '0;
    logic              REG_RVALID = 1'b0;
    logic              BUSY;
    logic              ERR;

    spi_reg_sequencer #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .SSEL_ACTIVE(SSEL_ACTIVE),
        .WORD_VALID(WORD_VALID), .WORD_IN(WORD_IN),
        .TX_LOAD(TX_LOAD), .TX_WORD(TX_WORD),
        .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
        .REG_WE(REG_WE), .REG_RE(REG_RE),
        .REG_RDATA(REG_RDATA), .REG_RVALID(REG_RVALID),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int tx_cnt = 0;
    int pend_cnt = 0;
    int pend_addr = 0;
    bit bus_en = 1'b1;
    int exp_wa[$];
    logic [15:0] exp_wd[$];
    logic [15:0] exp_tx[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, score strobes, advance the bus model.
    task automatic tick();
        int a;
        logic [15:0] d;
        @(negedge SYS_CLK);
        REG_RVALID = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                REG_RVALID = 1'b1;
                REG_RDATA  = 16'hA000 + 16'(pend_addr);
            end
        end
        if (REG_RE) begin
            re_cnt++;
            if (bus_en) begin
                pend_cnt  = 3;
                pend_addr = int'(REG_ADDR);
            end
        end
        if (REG_WE || REG_RE) chk("we_re_exclusive", {63'd0, REG_WE & REG_RE}, 64'd0);
        if (REG_WE) begin
            we_cnt++;
            chk("we_expected", {63'd0, exp_wa.size() != 0}, 64'd1);
            if (exp_wa.size() != 0) begin
                a = exp_wa.pop_front();
                d = exp_wd.pop_front();
                chk("we_addr", 64'(REG_ADDR), 64'(a));
                chk("we_data", 64'(REG_WDATA), 64'(d));
            end
        end
        if (TX_LOAD) begin
            tx_cnt++;
            chk("tx_expected", {63'd0, exp_tx.size() != 0}, 64'd1);
            if (exp_tx.size() != 0) begin
                d = exp_tx.pop_front();
                chk("tx_word", 64'(TX_WORD), 64'(d));
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        WORD_IN    = w;
        WORD_VALID = 1'b1;
        tick();
        WORD_VALID = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 30 && tx_cnt < target; i++) tick();
        chk("tx_arrived", 64'(tx_cnt), 64'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {TX_LOAD, TX_WORD, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY, ERR}, 64'd0);
    endtask

    initial begin
        int t;
        int r0;
        logic [15:0] first_rd;
        bit exp_re;

        repeat (3) tick();
        chk_reset_outputs("reset_state");
        RST = 1'b0;
        tick();

        // Write burst: two words at 5 and 6
        SSEL_ACTIVE = 1'b1;
        tick();
        chk("busy_after_ssel", {63'd0, BUSY}, 64'd1);
        exp_wa.push_back(5); exp_wd.push_back(16'h1234);
        exp_wa.push_back(6); exp_wd.push_back(16'h5678);
        send_word(16'h8502);
        send_word(16'h1234);
        send_word(16'h5678);
        tick();
        send_word(16'h9999);
        chk("wr_drained", 64'(exp_wa.size()), 64'd0);
        chk("wr_busy_drain", {63'd0, BUSY}, 64'd1);
        SSEL_ACTIVE = 1'b0;
        tick();
        chk("wr_idle", {63'd0, BUSY}, 64'd0);
        chk("wr_err", {63'd0, ERR}, 64'd0);

        // Read burst from 7F wrapping to 0
`ifdef SPI_SEQ_STATUS_EN
        first_rd = 16'h4002;
        exp_re   = 1'b0;
`else
        first_rd = 16'hA07F;
        exp_re   = 1'b1;
`endif
        SSEL_ACTIVE = 1'b1;
        tick();
        t = tx_cnt;
        exp_tx.push_back(first_rd);
        exp_tx.push_back(16'hA000);
        send_word(16'h7F02);
        chk("rd_re_latency", {63'd0, REG_RE}, 64'(exp_re));
        chk("rd_addr0", 64'(REG_ADDR), 64'h7F);
        wait_tx(t + 1);
        send_word(16'h0000);
        chk("rd_re_wrap", {63'd0, REG_RE}, 64'd1);
        chk("rd_addr_wrap", 64'(REG_ADDR), 64'd0);
        wait_tx(t + 2);
        send_word(16'h0000);
        tick();
        chk("rd_busy_drain", {63'd0, BUSY}, 64'd1);
        SSEL_ACTIVE = 1'b0;
        tick();
        chk("rd_idle", {63'd0, BUSY}, 64'd0);
        chk("rd_err", {63'd0, ERR}, 64'd0);

        // Zero count header, then a new header clears ERR
        SSEL_ACTIVE = 1'b1;
        tick();
        send_word(16'h8300);
        chk("zero_err_set", {63'd0, ERR}, 64'd1);
        send_word(16'h1111);
        SSEL_ACTIVE = 1'b0;
        tick();
        chk("zero_err_sticky", {63'd0, ERR}, 64'd1);
        SSEL_ACTIVE = 1'b1;
        tick();
        t = tx_cnt;
        exp_tx.push_back(16'hA003);
        send_word(16'h0301);
        chk("hdr_clears_err", {63'd0, ERR}, 64'd0);
        wait_tx(t + 1);
        send_word(16'h0000);
        SSEL_ACTIVE = 1'b0;
        tick();

        // Read timeout with a silent bus
        bus_en = 1'b0;
        SSEL_ACTIVE = 1'b1;
        tick();
        t = tx_cnt;
        exp_tx.push_back(16'hDEAD);
        send_word(16'h0401);
        chk("to_re", {63'd0, REG_RE}, 64'd1);
        for (int i = 1; i < RD_TIMEOUT; i++) tick();
        chk("to_err_before", {63'd0, ERR}, 64'd0);
        tick();
        chk("to_err_at", {63'd0, ERR}, 64'd1);
        chk("to_tx_loaded", 64'(tx_cnt), 64'(t + 1));
        SSEL_ACTIVE = 1'b0;
        tick();
        bus_en = 1'b1;

        // Abort partway through a 4-word write; the word coincident with the drop is lost
        SSEL_ACTIVE = 1'b1;
        tick();
        t = we_cnt;
        exp_wa.push_back(16); exp_wd.push_back(16'hAAAA);
        exp_wa.push_back(17); exp_wd.push_back(16'hBBBB);
        send_word(16'h9004);
        chk("abort_hdr_clears_err", {63'd0, ERR}, 64'd0);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        WORD_IN     = 16'hCCCC;
        WORD_VALID  = 1'b1;
        SSEL_ACTIVE = 1'b0;
        tick();
        WORD_VALID = 1'b0;
        chk("abort_idle", {63'd0, BUSY}, 64'd0);
        tick();
        chk("abort_we_count", 64'(we_cnt), 64'(t + 2));
        chk("abort_err", {63'd0, ERR}, 64'd0);

        // Reset mid-read; the in-flight reply must not surface
        SSEL_ACTIVE = 1'b1;
        tick();
        send_word(16'h2001);
        tick();
        RST = 1'b1;
        #1;
        chk_reset_outputs("rst_immediate");
        SSEL_ACTIVE = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        repeat (4) tick();
        chk_reset_outputs("rst_after");

`ifdef SPI_SEQ_STATUS_EN
        SSEL_ACTIVE = 1'b1;
        tick();
        t  = tx_cnt;
        r0 = re_cnt;
        exp_tx.push_back(16'h4001);
        send_word(16'h7F01);
        wait_tx(t + 1);
        chk("status_no_re", 64'(re_cnt), 64'(r0));
        send_word(16'h0000);
        SSEL_ACTIVE = 1'b0;
        tick();
`else
        r0 = re_cnt;
`endif

        chk("wr_queue_empty", 64'(exp_wa.size()), 64'd0);
        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
